// File: rtl/seg_serial_adder.sv
// Segment-serial signed adder/subtractor: one SEG_W-bit slice per clock, carry
// held between slices, with carry-out, signed overflow and selectable overflow result.
module seg_serial_adder #(
  parameter int WIDTH    = 33,
  parameter int SEG_W    = 8,
  parameter int OVF_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG   = (WIDTH + SEG_W - 1) / SEG_W;
  localparam int LAST_W = WIDTH - (NSEG - 1) * SEG_W;
  localparam int IDXW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, res;
  logic             carry, cout_r, ovf_r;
  logic [IDXW-1:0]  idx;
  logic             accept, last_seg;
  logic [31:0]      shamt;
  logic [SEG_W-1:0] seg_a, seg_b;
  logic [SEG_W:0]   seg_sum;
  logic [WIDTH-1:0] raw, final_s;
  logic             msb_cin, raw_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign last_seg = (state == RUN) && (idx == LAST_IDX);

  // The last slice may be narrower than SEG_W; the right shift zero-fills its unused
  // upper bits, so the MSB carry-out lands at seg_sum[LAST_W].
  always_comb begin
    shamt   = 32'(idx) * 32'(SEG_W);
    seg_a   = SEG_W'(a_r >> shamt);
    seg_b   = SEG_W'(b_r >> shamt);
    seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, carry};
    raw     = res | (WIDTH'(seg_sum[SEG_W-1:0]) << shamt);
    msb_cin = seg_sum[LAST_W-1] ^ a_r[WIDTH-1] ^ b_r[WIDTH-1];
    raw_ovf = msb_cin ^ seg_sum[LAST_W];
    final_s = raw;
    if (raw_ovf) begin
      if (OVF_MODE == 1)
        final_s = '0;
      else if (OVF_MODE == 2)
        final_s = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      res    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      carry <= cin ^ sub;
      idx   <= '0;
      res   <= '0;
    end else if (state == RUN) begin
      carry <= seg_sum[SEG_W];
      if (last_seg) begin
        res    <= final_s;
        cout_r <= seg_sum[LAST_W];
        ovf_r  <= raw_ovf;
      end else begin
        res <= raw;
        idx <= idx + IDXW'(1);
      end
    end
  end

  assign s    = res;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule
